// File: rtl/vga_pattern_gen_pkg.sv
// Shared definitions for the VGA pattern generator: mode encodings and
// constant helper functions used to size counters and address ports.
package vga_pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_BARS   = 2'd0,
    MODE_CHECK  = 2'd1,
    MODE_SPRITE = 2'd2,
    MODE_GRAD   = 2'd3
  } mode_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Never returns a zero width, so degenerate parameters still give legal vectors.
  function automatic int width_of(input int count);
    return (clog2(count) < 1) ? 1 : clog2(count);
  endfunction

  function automatic int total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_pattern_gen_timing.sv
// Pixel strobe divider, line/frame counters and raw sync/active decode.
// The sync and active levels here are combinational; the top registers them.
module vga_pattern_gen_timing import vga_pattern_gen_pkg::*; #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CLK_DIV  = 2,
  parameter int   HW       = 10,
  parameter int   VW       = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          pix_en,
  output logic          pclk,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          h_sync,
  output logic          v_sync,
  output logic          active,
  output logic          frame_end
);

  localparam int H_TOT = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DW    = width_of(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST    = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF    = DW'(CLK_DIV / 2);
  localparam logic [HW-1:0] H_LAST      = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT       = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_ON   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_LAST = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST      = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT       = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_ON   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_LAST = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DW-1:0] div_cnt;
  logic          line_end;

  assign pix_en    = (div_cnt == DIV_LAST);
  assign line_end  = (h_cnt == H_LAST);
  assign frame_end = pix_en && line_end && (v_cnt == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      pclk    <= 1'b0;
    end else begin
      div_cnt <= pix_en ? '0 : div_cnt + 1'b1;
      pclk    <= (div_cnt >= DIV_HALF);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (line_end) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  assign h_sync = (h_cnt >= H_SYNC_ON && h_cnt <= H_SYNC_LAST) ? HS_POL : ~HS_POL;
  assign v_sync = (v_cnt >= V_SYNC_ON && v_cnt <= V_SYNC_LAST) ? VS_POL : ~VS_POL;
  assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);

endmodule

// File: rtl/vga_pattern_gen.sv
// Parametrised VGA timing generator with bars/checker/sprite/gradient images.
// Every output is registered on the pixel strobe, giving one pixel of latency.
module vga_pattern_gen import vga_pattern_gen_pkg::*; #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic HS_POL    = 1'b0,
  parameter logic VS_POL    = 1'b0,
  parameter int   CLK_DIV   = 2,
  parameter int   COLOR_W   = 8,
  parameter int   SPR_W     = 64,
  parameter int   SPR_H     = 48,
  parameter int   STEP      = 2,
  parameter int   CHK_SHIFT = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   mode,
  input  logic                         pause,
  output logic                         pclk,
  output logic                         hsync,
  output logic                         vsync,
  output logic                         valid,
  output logic [COLOR_W-1:0]           vga_r,
  output logic [COLOR_W-1:0]           vga_g,
  output logic [COLOR_W-1:0]           vga_b,
  output logic [clog2(H_ACTIVE)-1:0]   h_addr,
  output logic [clog2(V_ACTIVE)-1:0]   v_addr,
  output logic                         frame_start
);

  localparam int HW    = width_of(total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int VW    = width_of(total(V_ACTIVE, V_FP, V_SYNC, V_BP));
  localparam int AW    = clog2(H_ACTIVE);
  localparam int BW    = clog2(V_ACTIVE);
  localparam int X_MAX = H_ACTIVE - SPR_W;
  localparam int Y_MAX = V_ACTIVE - SPR_H;
  localparam logic [COLOR_W-1:0] MAX = '1;

  logic          pix_en;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_sync_now;
  logic          v_sync_now;
  logic          active;
  logic          frame_end;

  vga_pattern_gen_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .HS_POL   (HS_POL),   .VS_POL (VS_POL), .CLK_DIV (CLK_DIV),
    .HW       (HW),       .VW (VW)
  ) u_timing (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_en    (pix_en),
    .pclk      (pclk),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .h_sync    (h_sync_now),
    .v_sync    (v_sync_now),
    .active    (active),
    .frame_end (frame_end)
  );

  mode_t               mode_q;
  logic [AW-1:0]       spr_x, spr_x_next;
  logic [BW-1:0]       spr_y, spr_y_next;
  logic                dx_pos, dx_next;
  logic                dy_pos, dy_next;
  logic [2:0]          bar_i;
  logic                check_on;
  logic                in_sprite;
  logic [COLOR_W-1:0]  r_next, g_next, b_next;

  // Mode and sprite only change at the frame wrap, so a frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_BARS;
      spr_x  <= '0;
      spr_y  <= '0;
      dx_pos <= 1'b1;
      dy_pos <= 1'b1;
    end else if (frame_end) begin
      mode_q <= mode_t'(mode);
      if (!pause) begin
        spr_x  <= spr_x_next;
        spr_y  <= spr_y_next;
        dx_pos <= dx_next;
        dy_pos <= dy_next;
      end
    end
  end

  always_comb begin
    spr_x_next = spr_x;
    dx_next    = dx_pos;
    if (dx_pos) begin
      if (int'(spr_x) + STEP > X_MAX) begin
        spr_x_next = AW'(X_MAX);
        dx_next    = 1'b0;
      end else begin
        spr_x_next = AW'(int'(spr_x) + STEP);
      end
    end else if (int'(spr_x) < STEP) begin
      spr_x_next = '0;
      dx_next    = 1'b1;
    end else begin
      spr_x_next = AW'(int'(spr_x) - STEP);
    end
  end

  always_comb begin
    spr_y_next = spr_y;
    dy_next    = dy_pos;
    if (dy_pos) begin
      if (int'(spr_y) + STEP > Y_MAX) begin
        spr_y_next = BW'(Y_MAX);
        dy_next    = 1'b0;
      end else begin
        spr_y_next = BW'(int'(spr_y) + STEP);
      end
    end else if (int'(spr_y) < STEP) begin
      spr_y_next = '0;
      dy_next    = 1'b1;
    end else begin
      spr_y_next = BW'(int'(spr_y) - STEP);
    end
  end

  // Bar 0 (leftmost) maps to index 7 so that it comes out white.
  assign bar_i     = 3'(7 - (int'(h_cnt) * 8) / H_ACTIVE);
  assign check_on  = 1'(h_cnt >> CHK_SHIFT) ^ 1'(v_cnt >> CHK_SHIFT);
  assign in_sprite = (int'(h_cnt) >= int'(spr_x)) && (int'(h_cnt) < int'(spr_x) + SPR_W) &&
                     (int'(v_cnt) >= int'(spr_y)) && (int'(v_cnt) < int'(spr_y) + SPR_H);

  always_comb begin
    r_next = '0;
    g_next = '0;
    b_next = '0;
    if (active) begin
      case (mode_q)
        MODE_BARS: begin
          r_next = bar_i[2] ? MAX : '0;
          g_next = bar_i[1] ? MAX : '0;
          b_next = bar_i[0] ? MAX : '0;
        end
        MODE_CHECK: begin
          if (check_on) begin
            r_next = MAX;
            g_next = MAX;
            b_next = MAX;
          end
        end
        MODE_SPRITE: begin
          b_next = MAX;
          if (in_sprite) begin
            r_next = MAX;
            g_next = MAX;
          end
        end
        MODE_GRAD: begin
          r_next = COLOR_W'(h_cnt);
          g_next = COLOR_W'(v_cnt);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      valid       <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      h_addr      <= '0;
      v_addr      <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && (h_cnt == '0) && (v_cnt == '0);
      if (pix_en) begin
        hsync  <= h_sync_now;
        vsync  <= v_sync_now;
        valid  <= active;
        vga_r  <= r_next;
        vga_g  <= g_next;
        vga_b  <= b_next;
        h_addr <= active ? AW'(h_cnt) : '0;
        v_addr <= active ? BW'(v_cnt) : '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench: random mode/pause stimulus compared every clock against
// a frame-level model that derives each pixel from a linear pixel count.
module tb_vga_pattern_gen;

  localparam int H_ACTIVE = 16, H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int V_ACTIVE = 8,  V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int CLK_DIV = 2, COLOR_W = 8, SPR_W = 4, SPR_H = 2, STEP = 2, CHK_SHIFT = 1;
  localparam int H_TOT = 24, V_TOT = 12;
  localparam int FRAME_PIX  = H_TOT * V_TOT;
  localparam int FRAME_CLKS = FRAME_PIX * CLK_DIV;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [1:0]          mode;
  logic                pause;
  logic                pclk, hsync, vsync, valid, frame_start;
  logic [COLOR_W-1:0]  vga_r, vga_g, vga_b;
  logic [3:0]          h_addr;
  logic [2:0]          v_addr;

  always #5 clk = ~clk;

  vga_pattern_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .HS_POL (1'b0), .VS_POL (1'b0), .CLK_DIV (CLK_DIV), .COLOR_W (COLOR_W),
    .SPR_W (SPR_W), .SPR_H (SPR_H), .STEP (STEP), .CHK_SHIFT (CHK_SHIFT)
  ) dut (
    .clk (clk), .rst_n (rst_n), .mode (mode), .pause (pause),
    .pclk (pclk), .hsync (hsync), .vsync (vsync), .valid (valid),
    .vga_r (vga_r), .vga_g (vga_g), .vga_b (vga_b),
    .h_addr (h_addr), .v_addr (v_addr), .frame_start (frame_start)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state: clocks and pixels since reset release, frame-level mode and sprite.
  int   clk_cnt, pix_count, mode_lat, spr_x, spr_y;
  bit   dx_pos, dy_pos, last_strobe;
  logic e_pclk, e_fs, e_hs, e_vs, e_valid;
  logic [6:0]  e_addr;
  logic [23:0] e_rgb;

  // Bar colours left to right for bars 0..7.
  logic [23:0] bar_rgb [8] = '{24'hFFFFFF, 24'hFFFF00, 24'hFF00FF, 24'hFF0000,
                               24'h00FFFF, 24'h00FF00, 24'h0000FF, 24'h000000};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] pixelColor(input int h, input int v);
    if (h >= H_ACTIVE || v >= V_ACTIVE) return 24'h0;
    case (mode_lat)
      0: return bar_rgb[h / (H_ACTIVE / 8)];
      1: return (((h >> CHK_SHIFT) + (v >> CHK_SHIFT)) % 2 == 1) ? 24'hFFFFFF : 24'h0;
      2: return (h >= spr_x && h < spr_x + SPR_W && v >= spr_y && v < spr_y + SPR_H)
                ? 24'hFFFFFF : 24'h0000FF;
      default: return 24'((h % 256) << 16 | (v % 256) << 8);
    endcase
  endfunction

  task automatic moveSprite();
    if (dx_pos) begin
      if (spr_x + STEP > H_ACTIVE - SPR_W) begin spr_x = H_ACTIVE - SPR_W; dx_pos = 0; end
      else spr_x += STEP;
    end else if (spr_x < STEP) begin spr_x = 0; dx_pos = 1; end
    else spr_x -= STEP;
    if (dy_pos) begin
      if (spr_y + STEP > V_ACTIVE - SPR_H) begin spr_y = V_ACTIVE - SPR_H; dy_pos = 0; end
      else spr_y += STEP;
    end else if (spr_y < STEP) begin spr_y = 0; dy_pos = 1; end
    else spr_y -= STEP;
  endtask

  task automatic modelReset();
    clk_cnt = 0; pix_count = 0; mode_lat = 0;
    spr_x = 0; spr_y = 0; dx_pos = 1; dy_pos = 1; last_strobe = 0;
    e_pclk = 0; e_fs = 0; e_hs = 1; e_vs = 1; e_valid = 0; e_addr = '0; e_rgb = '0;
  endtask

  // Advance the model by one clock edge using the inputs held across that edge.
  task automatic modelEdge();
    int  h, v;
    bit  act;
    clk_cnt++;
    e_pclk = (((clk_cnt - 1) % CLK_DIV) >= CLK_DIV / 2);
    e_fs = 0;
    last_strobe = (clk_cnt % CLK_DIV == 0);
    if (last_strobe) begin
      h   = pix_count % H_TOT;
      v   = (pix_count / H_TOT) % V_TOT;
      act = (h < H_ACTIVE) && (v < V_ACTIVE);
      e_hs    = !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
      e_vs    = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
      e_valid = act;
      e_addr  = act ? 7'(h * 8 + v) : 7'd0;
      e_rgb   = pixelColor(h, v);
      e_fs    = (h == 0 && v == 0);
      if (h == H_TOT - 1 && v == V_TOT - 1) begin
        mode_lat = mode;
        if (!pause) moveSprite();
      end
      pix_count++;
    end
  endtask

  task automatic checkAll();
    checkOutput("pclk", pclk, e_pclk);
    checkOutput("frame_start", frame_start, e_fs);
    checkOutput("hsync_vsync_valid", {hsync, vsync, valid}, {e_hs, e_vs, e_valid});
    checkOutput("addr", {h_addr, v_addr}, e_addr);
    checkOutput("rgb", {vga_r, vga_g, vga_b}, e_rgb);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pclk"}, pclk, 0);
    checkOutput({tag, "_frame_start"}, frame_start, 0);
    checkOutput({tag, "_hsync_vsync_valid"}, {hsync, vsync, valid}, 3'b110);
    checkOutput({tag, "_addr"}, {h_addr, v_addr}, 0);
    checkOutput({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
  endtask

  task automatic applyStimulus(input int n, input bit random_inputs);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      checkAll();
      if (random_inputs) begin
        if ($urandom_range(0, 399) == 0) mode = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 1499) == 0) pause = ~pause;
      end
    end
  endtask

  initial begin
    bit found;
    rst_n = 1'b0;
    mode  = 2'd0;
    pause = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;

    // Frame 0 is bars regardless of the input; the checker follows.
    mode = 2'd1;
    applyStimulus(FRAME_CLKS * 2, 0);
    mode = 2'd2;
    applyStimulus(FRAME_CLKS * 9, 0);
    pause = 1'b1;
    applyStimulus(FRAME_CLKS * 3, 0);
    pause = 1'b0;
    applyStimulus(FRAME_CLKS * 5, 1);

    // Reset asserted mid-frame, right after pixel (10,4) has been output.
    found = 0;
    for (int i = 0; i < FRAME_CLKS * 2 && !found; i++) begin
      applyStimulus(1, 0);
      if (last_strobe && ((pix_count - 1) % FRAME_PIX) == 4 * H_TOT + 10) found = 1;
    end
    checkOutput("reach_pixel_10_4", found, 1);
    rst_n = 1'b0;
    #1;
    checkResetValues("midframe_reset");
    repeat (2) @(negedge clk);
    checkResetValues("reset_held");
    modelReset();
    rst_n = 1'b1;
    mode  = 2'd3;
    applyStimulus(FRAME_CLKS * 2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Parametrised VGA timing generator with a built-in pattern and sprite engine; successor to the fixed 640x480 flying-logo top.
- Derives the pixel strobe and pixel clock from the board clock, generates sync, blank and addresses, and renders one of four mode-selected images.
- Mode 2 renders a bouncing box sprite.
- Sits directly behind the board VGA pins; a separate display top instantiates it.

Parameters:
- H_ACTIVE, 640, visible pixels per line (multiple of 8)
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch in pixels
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porches and sync in lines
- HS_POL / VS_POL, 0 / 0, level of hsync / vsync during the sync interval
- CLK_DIV, 2, clk cycles per pixel (>=2)
- COLOR_W, 8, bits per colour channel
- SPR_W / SPR_H, 64 / 48, sprite size in pixels
- STEP, 2, sprite motion per frame in pixels, each axis
- CHK_SHIFT, 5, checker cell is 2^CHK_SHIFT pixels square

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- mode  in  2  0 colour bars, 1 checker, 2 sprite, 3 gradient
- pause  in  1  freezes sprite motion
- pclk  out  1  pixel clock to the DAC
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- valid  out  1  active-video (BLANK_N)
- vga_r / vga_g / vga_b  out  COLOR_W each  pixel colour
- h_addr / v_addr  out  clog2(H_ACTIVE) / clog2(V_ACTIVE)  current active-pixel coordinate
- frame_start  out  1  one-clk pulse at pixel (0,0)

Behaviour:
- Reset: asynchronous, active-low, as decided. All counters clear to 0. hsync=~HS_POL, vsync=~VS_POL, valid=0, RGB=0, frame_start=0, pclk=0. Sprite x=y=0 with dx=+STEP, dy=+STEP. Latched mode=0.
- Divider: div_cnt counts 0..CLK_DIV-1. pix_en=1 when div_cnt==CLK_DIV-1. pclk is registered, equal to (div_cnt>=CLK_DIV/2).
- Counters:
  - h_cnt advances on pix_en and wraps at H_TOT=H_ACTIVE+H_FP+H_SYNC+H_BP.
  - v_cnt advances when h_cnt wraps, and wraps at V_TOT.
  - Line order: active, FP, sync, BP. Sync is asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vertical is the same.
- Output pipeline: all outputs are registered on pix_en and reflect the counter values before that edge, so there is exactly one pixel of latency, identical for sync, valid, address and colour.
  - Outside active video, RGB=0 and addresses hold 0.
- frame_start: high for the single clk cycle of the pix_en on which outputs for (0,0) are registered.
- Mode latch: mode is sampled only when the counters wrap to (0,0). A mid-frame change takes effect at the next frame; no tearing.
- Patterns (active region; MAX = all ones):
  - Mode 0: bar b = h_cnt*8/H_ACTIVE, i=7-b. R=MAX if i[2], G=MAX if i[1], B=MAX if i[0]. Bar 0 is white, bar 7 is black.
  - Mode 1: white if h_cnt[CHK_SHIFT]^v_cnt[CHK_SHIFT], else black.
  - Mode 2: white inside [x, x+SPR_W) x [y, y+SPR_H), else pure blue.
  - Mode 3: R = h_cnt[COLOR_W-1:0], G = v_cnt[COLOR_W-1:0], B=0.
- Sprite update:
  - Happens once per frame, on the pix_en where (h_cnt,v_cnt)=(H_TOT-1,V_TOT-1), when pause=0. The sprite moves in all modes.
  - x axis: nx = x+dx. If dx>0 and nx > H_ACTIVE-SPR_W, then x=H_ACTIVE-SPR_W and dx=-STEP. If dx<0 and x<STEP, then x=0 and dx=+STEP. Otherwise x=nx. The y axis is identical against V_ACTIVE-SPR_H.
  - A position exactly on an edge is legal; it reverses on the next update.
- Reset mid-frame: everything returns to reset values immediately; the first frame after release starts at (0,0) with frame_start.

Decomposition:
- Shared package: H_TOT/V_TOT computation function, mode encodings (MODE_BARS, MODE_CHECK, MODE_SPRITE, MODE_GRAD), clog2 function.
- Sub-module vga_timing: divider, counters, sync/valid generation, and pix_en/wrap strobes.
- The top holds the mode latch, sprite state, pattern mux and output registers.

Test Plan:
All scenarios use H 16/2/3/3 (H_TOT=24), V 8/1/2/1 (V_TOT=12), CLK_DIV=2, SPR 4x2, STEP=2, CHK_SHIFT=1.
- Timing: after reset release, hsync low for 3 pixels (6 clk) starting 18 pixels after frame_start. Period 48 clk. vsync low for 2 lines. frame_start period 576 clk. pclk period 2 clk.
- Bars: mode 0 on line 0 -> pixels 0-1 white (MAX,MAX,MAX), 2-3 yellow (MAX,MAX,0), 14-15 black. Outside active: RGB=0, valid=0.
- Checker: mode 1 -> (h2,v0) white, (h2,v2) black, (h0,v0) black.
- Sprite bounce: x sequence 0,2,4,6,8,10,12,12,10,...; y sequence 0,2,4,6,6,4. With pause=1 the position holds across 3 frames.
- Mode latch: change mode 0->3 at pixel (5,3) -> frame continues as bars; the next frame pixel (5,3) shows R=5, G=3, B=0.
- Reset mid-frame: assert rst_n=0 at pixel (10,4) -> all outputs at reset values within the same cycle. Release -> frame_start after exactly one pixel strobe.
